midi_byte_parser: RTL and testbench

Consumes the UART receive byte stream (8-bit data plus valid/ready) and assembles complete MIDI channel-voice messages for the synth voice logic.
- Handles running status, system real-time bytes interleaved inside messages, SysEx skipping and optional channel filtering.
- Presents one decoded message at a time on a registered valid/ready output.

---
 rtl/midi_byte_parser_if.sv | 21 ++
 rtl/midi_byte_parser.sv | 98 +++++++++
 tb/tb_midi_byte_parser.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/midi_byte_parser_if.sv
// midi_byte_parser_if: UART byte input and decoded MIDI message output of the parser
interface midi_byte_parser_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       msg_valid;
  logic       msg_ready;
  logic [2:0] msg_type;
  logic [3:0] msg_chan;
  logic [6:0] msg_d1;
  logic [6:0] msg_d2;
  logic [7:0] drop_count;
  modport master (
    output rx_data, rx_valid, msg_ready,
    input  rx_ready, msg_valid, msg_type, msg_chan, msg_d1, msg_d2, drop_count
  );
  modport slave (
    input  rx_data, rx_valid, msg_ready,
    output rx_ready, msg_valid, msg_type, msg_chan, msg_d1, msg_d2, drop_count
  );
endinterface

// File: rtl/midi_byte_parser.sv
// midi_byte_parser: assembles MIDI channel-voice messages from a UART byte stream
module midi_byte_parser #(
  parameter bit         OMNI        = 1'b1,
  parameter logic [3:0] CHANNEL     = 4'd0,
  parameter bit         VEL0_IS_OFF = 1'b1
) (
  input logic clk,
  input logic nrst,
  midi_byte_parser_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SYSEX} state_t;
  state_t     r_state, w_state_nxt;
  logic [2:0] r_type, w_type_nxt;
  logic [3:0] r_chan, w_chan_nxt;
  logic [6:0] r_d1, w_d1_nxt;
  logic       r_msg_valid;
  logic [2:0] r_msg_type;
  logic [3:0] r_msg_chan;
  logic [6:0] r_msg_d1, r_msg_d2;
  logic [7:0] r_drop;
  logic       w_rx_ready, w_acc, w_done, w_drop, w_pass;
  logic [6:0] w_out_d1, w_out_d2;
  logic [2:0] w_out_type;
  assign w_rx_ready = !r_msg_valid || bus.msg_ready;
  assign w_acc      = bus.rx_valid && w_rx_ready;
  always_comb begin
    w_state_nxt = r_state;
    w_type_nxt  = r_type;
    w_chan_nxt  = r_chan;
    w_d1_nxt    = r_d1;
    w_done      = 1'b0;
    w_drop      = 1'b0;
    if (w_acc) begin
      if (!bus.rx_data[7]) begin
        case (r_state)
          IDLE: w_drop = 1'b1;
          WAIT_D1: begin
            w_d1_nxt    = bus.rx_data[6:0];
            w_done      = r_type == 3'd4 || r_type == 3'd5;
            w_state_nxt = w_done ? WAIT_D1 : WAIT_D2;
          end
          WAIT_D2: begin
            w_done      = 1'b1;
            w_state_nxt = WAIT_D1;
          end
          default: ;
        endcase
      end else if (bus.rx_data[7:4] != 4'hF) begin
        w_state_nxt = WAIT_D1;
        w_type_nxt  = bus.rx_data[6:4];
        w_chan_nxt  = bus.rx_data[3:0];
      end else if (!bus.rx_data[3]) begin
        // 0xF8-0xFF real-time bytes fall through untouched
        w_state_nxt = bus.rx_data[2:0] == 3'd0 ? SYSEX : IDLE;
      end
    end
  end
  assign w_out_d1   = r_state == WAIT_D1 ? bus.rx_data[6:0] : r_d1;
  assign w_out_d2   = r_state == WAIT_D2 ? bus.rx_data[6:0] : 7'd0;
  assign w_out_type = (VEL0_IS_OFF && r_type == 3'd1 && w_out_d2 == 7'd0) ? 3'd0 : r_type;
  assign w_pass     = OMNI || r_chan == CHANNEL;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= IDLE;
      r_type      <= 3'd0;
      r_chan      <= 4'd0;
      r_d1        <= 7'd0;
      r_msg_valid <= 1'b0;
      r_msg_type  <= 3'd0;
      r_msg_chan  <= 4'd0;
      r_msg_d1    <= 7'd0;
      r_msg_d2    <= 7'd0;
      r_drop      <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_type  <= w_type_nxt;
      r_chan  <= w_chan_nxt;
      r_d1    <= w_d1_nxt;
      if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      if (w_done && w_pass) begin
        r_msg_valid <= 1'b1;
        r_msg_type  <= w_out_type;
        r_msg_chan  <= r_chan;
        r_msg_d1    <= w_out_d1;
        r_msg_d2    <= w_out_d2;
      end else if (bus.msg_ready) begin
        r_msg_valid <= 1'b0;
      end
    end
  end
  assign bus.rx_ready   = w_rx_ready;
  assign bus.msg_valid  = r_msg_valid;
  assign bus.msg_type   = r_msg_type;
  assign bus.msg_chan   = r_msg_chan;
  assign bus.msg_d1     = r_msg_d1;
  assign bus.msg_d2     = r_msg_d2;
  assign bus.drop_count = r_drop;
endmodule

// File: tb/tb_midi_byte_parser.sv
// tb_midi_byte_parser: scoreboard bench for three parser configurations sharing one stimulus source
module tb_midi_byte_parser;
  typedef struct packed {
    logic [2:0] t;
    logic [3:0] c;
    logic [6:0] d1;
    logic [6:0] d2;
  } msg_t;
  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic       msg_ready = 1'b1;
  int         sel = 0;
  int         errors = 0;
  int         checks = 0;
  msg_t       exp_q[$];
  midi_byte_parser_if ifa ();
  midi_byte_parser_if ifb ();
  midi_byte_parser_if ifc ();
  always #5 clk = ~clk;
  assign ifa.rx_data = rx_data;
  assign ifb.rx_data = rx_data;
  assign ifc.rx_data = rx_data;
  assign ifa.rx_valid = rx_valid && sel == 0;
  assign ifb.rx_valid = rx_valid && sel == 1;
  assign ifc.rx_valid = rx_valid && sel == 2;
  assign ifa.msg_ready = msg_ready;
  assign ifb.msg_ready = msg_ready;
  assign ifc.msg_ready = msg_ready;
  midi_byte_parser dut_a (.clk(clk), .nrst(nrst), .bus(ifa));
  midi_byte_parser #(.VEL0_IS_OFF(1'b0)) dut_b (.clk(clk), .nrst(nrst), .bus(ifb));
  midi_byte_parser #(.OMNI(1'b0), .CHANNEL(4'd5)) dut_c (.clk(clk), .nrst(nrst), .bus(ifc));
  logic       s_rdy, s_valid;
  logic [7:0] s_drop;
  msg_t       s_msg;
  always_comb begin
    s_rdy   = sel == 0 ? ifa.rx_ready : sel == 1 ? ifb.rx_ready : ifc.rx_ready;
    s_valid = sel == 0 ? ifa.msg_valid : sel == 1 ? ifb.msg_valid : ifc.msg_valid;
    s_drop  = sel == 0 ? ifa.drop_count : sel == 1 ? ifb.drop_count : ifc.drop_count;
    s_msg   = sel == 0 ? {ifa.msg_type, ifa.msg_chan, ifa.msg_d1, ifa.msg_d2} :
              sel == 1 ? {ifb.msg_type, ifb.msg_chan, ifb.msg_d1, ifb.msg_d2} :
                         {ifc.msg_type, ifc.msg_chan, ifc.msg_d1, ifc.msg_d2};
  end
  always @(negedge clk) begin
    if (nrst && s_valid && msg_ready) begin
      checks += 1;
      if (exp_q.size() == 0) begin
        errors += 1;
        $display("FAIL unexpected_msg dut=%0d got=%h", sel, s_msg);
      end else begin
        msg_t e;
        e = exp_q.pop_front();
        if (s_msg !== e) begin
          errors += 1;
          $display("FAIL msg_fields dut=%0d got=%h exp=%h", sel, s_msg, e);
        end
      end
    end
  end
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_rdy) begin
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        return;
      end
    end
    checks += 1;
    errors += 1;
    rx_valid = 1'b0;
    $display("FAIL send_timeout byte=%h got=stalled exp=accepted", b);
  endtask
  task automatic drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    checks += 1;
    if (exp_q.size() != 0) begin
      errors += 1;
      $display("FAIL %s_missing got=%0d pending exp=0", name, exp_q.size());
      exp_q.delete();
    end
    checks += 1;
    if (s_valid !== 1'b0) begin
      errors += 1;
      $display("FAIL %s_valid_clear got=%b exp=0", name, s_valid);
    end
  endtask
  task automatic pulse_reset();
    nrst = 1'b0;
    @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks += 1;
    if (s_valid !== 1'b0 || s_msg !== '0 || s_drop !== 8'd0) begin
      errors += 1;
      $display("FAIL reset_outputs got=%b/%h/%h exp=0/0/0", s_valid, s_msg, s_drop);
    end
    checks += 1;
    if (s_rdy !== 1'b1) begin
      errors += 1;
      $display("FAIL reset_rx_ready got=%b exp=1", s_rdy);
    end
    nrst = 1'b1;
  endtask
  task automatic test_basic();
    exp_q.push_back('{3'd1, 4'd0, 7'h3C, 7'h64});
    send(8'h90);
    send(8'h3C);
    send(8'h64);
    checks += 1;
    if (s_valid !== 1'b1) begin
      errors += 1;
      $display("FAIL basic_latency got=%b exp=1", s_valid);
    end
    @(posedge clk);
    #1;
    checks += 1;
    if (s_valid !== 1'b0) begin
      errors += 1;
      $display("FAIL basic_single_cycle got=%b exp=0", s_valid);
    end
    drain("basic");
  endtask
  task automatic test_running(input logic [2:0] t2);
    exp_q.push_back('{3'd1, 4'd1, 7'h40, 7'h50});
    exp_q.push_back('{t2, 4'd1, 7'h41, 7'h00});
    send(8'h91);
    send(8'h40);
    send(8'h50);
    send(8'h41);
    send(8'h00);
    drain("running");
  endtask
  task automatic test_back_to_back();
    exp_q.push_back('{3'd4, 4'd6, 7'h01, 7'h00});
    exp_q.push_back('{3'd4, 4'd6, 7'h02, 7'h00});
    exp_q.push_back('{3'd5, 4'd6, 7'h03, 7'h00});
    send(8'hC6);
    send(8'h01);
    send(8'h02);
    checks += 1;
    if (s_valid !== 1'b1) begin
      errors += 1;
      $display("FAIL b2b_valid_held got=%b exp=1", s_valid);
    end
    send(8'hD6);
    send(8'h03);
    drain("b2b");
  endtask
  task automatic test_realtime();
    exp_q.push_back('{3'd3, 4'd2, 7'h07, 7'h7F});
    send(8'hB2);
    send(8'hF8);
    send(8'h07);
    send(8'hFE);
    send(8'h7F);
    drain("realtime");
    checks += 1;
    if (s_drop !== 8'd0) begin
      errors += 1;
      $display("FAIL realtime_drops got=%0d exp=0", s_drop);
    end
  endtask
  task automatic test_stray_sysex();
    pulse_reset();
    send(8'h10);
    send(8'h20);
    checks += 1;
    if (s_drop !== 8'd2) begin
      errors += 1;
      $display("FAIL stray_drops got=%0d exp=2", s_drop);
    end
    send(8'hF0);
    send(8'h01);
    send(8'h02);
    send(8'hF7);
    send(8'h05);
    checks += 1;
    if (s_drop !== 8'd3) begin
      errors += 1;
      $display("FAIL sysex_drops got=%0d exp=3", s_drop);
    end
    exp_q.push_back('{3'd4, 4'd3, 7'h05, 7'h00});
    send(8'hC3);
    send(8'h05);
    drain("sysex");
  endtask
  task automatic test_saturate();
    pulse_reset();
    for (int i = 0; i < 260; i++) send(8'h01);
    checks += 1;
    if (s_drop !== 8'hFF) begin
      errors += 1;
      $display("FAIL drop_saturate got=%0d exp=255", s_drop);
    end
  endtask
  task automatic test_backpressure();
    msg_t first;
    first = '{3'd6, 4'd0, 7'h00, 7'h40};
    msg_ready = 1'b0;
    exp_q.push_back(first);
    exp_q.push_back('{3'd6, 4'd0, 7'h12, 7'h34});
    send(8'hE0);
    send(8'h00);
    send(8'h40);
    fork
      begin
        send(8'h12);
        send(8'h34);
      end
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          checks += 1;
          if (s_valid !== 1'b1 || s_msg !== first) begin
            errors += 1;
            $display("FAIL bp_hold got=%b/%h exp=1/%h", s_valid, s_msg, first);
          end
          checks += 1;
          if (s_rdy !== 1'b0) begin
            errors += 1;
            $display("FAIL bp_rx_ready got=%b exp=0", s_rdy);
          end
        end
        @(posedge clk);
        #1;
        msg_ready = 1'b1;
      end
    join
    drain("backpressure");
  endtask
  task automatic test_filter_reset();
    send(8'h7F);
    send(8'h94);
    send(8'h10);
    send(8'h10);
    exp_q.push_back('{3'd0, 4'd5, 7'h20, 7'h30});
    send(8'h95);
    send(8'h10);
    send(8'h85);
    send(8'h20);
    send(8'h30);
    drain("filter");
    msg_ready = 1'b0;
    send(8'h95);
    send(8'h01);
    send(8'h02);
    checks += 1;
    if (s_valid !== 1'b1 || s_drop !== 8'd1) begin
      errors += 1;
      $display("FAIL prereset_state got=%b/%0d exp=1/1", s_valid, s_drop);
    end
    #2;
    nrst = 1'b0;
    #1;
    checks += 1;
    if (s_valid !== 1'b0 || s_msg !== '0 || s_drop !== 8'd0) begin
      errors += 1;
      $display("FAIL async_reset got=%b/%h/%0d exp=0/0/0", s_valid, s_msg, s_drop);
    end
    checks += 1;
    if (s_rdy !== 1'b1) begin
      errors += 1;
      $display("FAIL async_reset_ready got=%b exp=1", s_rdy);
    end
    @(posedge clk);
    #1;
    nrst = 1'b1;
    msg_ready = 1'b1;
    send(8'h20);
    checks += 1;
    if (s_drop !== 8'd1) begin
      errors += 1;
      $display("FAIL running_cleared got=%0d exp=1", s_drop);
    end
    drain("postreset");
  endtask
  initial begin
    test_reset();
    test_basic();
    test_running(3'd0);
    test_back_to_back();
    test_realtime();
    test_stray_sysex();
    test_saturate();
    test_backpressure();
    sel = 1;
    test_running(3'd1);
    sel = 2;
    test_filter_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
